issue_control: RTL and testbench
================================

ISSUE_CONTROL -- requirements
Module: issue_control

Interface
REQ-001 SHALL have parameter NUM_REGS, default 128, register-file entries tracked by scoreboard.
REQ-002 SHALL have parameter CNT_W, default 3, scoreboard countdown width (max latency 7).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1  decoded-pair handshake; pair accepted when both high.
REQ-006 SHALL have ports s0_valid, s1_valid  input  1 each  slot present; slot0 is older.
REQ-007 SHALL have ports s0_unit, s1_unit  input  UNIT_ID_SIZE  execution unit id.
REQ-008 SHALL have ports s0_wr, s1_wr input 1 and s0_rt, s1_rt input REG_ADDR_WIDTH  destination write enable/address.
REQ-009 SHALL have ports sN_ra, sN_rb, sN_rc  input  REG_ADDR_WIDTH and sN_use  input  3 (ra,rb,rc use bits), N=0,1.
REQ-010 SHALL have port flush  input  1  taken branch; discard pair and pending slot.
REQ-011 SHALL have ports even_issue, odd_issue  output  1  issue strobe per pipe.
REQ-012 SHALL have ports even_slot, odd_slot  output  1  slot issued on that pipe (0/1).
REQ-013 SHALL have port stall_cnt  output  32  cycles with in_valid high and nothing issued.

Function
REQ-014 SHALL map units fx1, byte, fx2, sp_fp, sp_int to even pipe; perm, ls, branch to odd pipe.
REQ-015 SHALL use unit latencies fx1=2, byte=3, fx2=3, perm=3, branch=3, sp_fp=6, ls=6, sp_int=7.
REQ-016 SHALL keep per-register countdown sb[r]; issue with wr=1 loads sb[rt]=latency; otherwise nonzero entries decrement by 1 per cycle.
REQ-017 SHALL treat a slot as RAW-blocked if any used source r has sb[r]!=0 (after considering same-cycle load).
REQ-018 SHALL treat a slot as WAW-blocked if wr=1 and sb[rt] > its latency.
REQ-019 SHALL implement FSM IDLE (no slot issued from current pair) and HALF (slot0 issued, slot1 pending).
REQ-020 SHALL in IDLE dual-issue both slots when both valid, on different pipes, slot1 sources/rt not equal to slot0 rt (when s0_wr), and neither blocked; assert in_ready.
REQ-021 SHALL in IDLE issue slot0 only and go HALF when slot1 valid but same pipe, dependent on slot0, or blocked; in_ready=0.
REQ-022 SHALL in IDLE issue nothing, in_ready=0, increment stall_cnt when slot0 blocked; slot1 never issues ahead of slot0.
REQ-023 SHALL in HALF issue slot1 when unblocked, assert in_ready, return IDLE; else stall and increment stall_cnt.
REQ-024 SHALL treat a pair with only s1_valid as a single slot1 instruction.
REQ-025 SHALL make issue strobes, slot selects and in_ready combinational from inputs, state and scoreboard.
REQ-026 SHALL require pair inputs stable while in_valid=1 and in_ready=0.
REQ-027 SHALL on flush force issues 0, in_ready 1, next state IDLE; scoreboard continues counting (in-flight results still write back).
REQ-028 SHALL saturate stall_cnt at 2^32-1.

Reset
REQ-029 SHALL on reset low asynchronously clear all sb entries, state=IDLE, stall_cnt=0.
REQ-030 SHALL hold in_ready, even_issue, odd_issue, even_slot, odd_slot at 0 while reset low.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts; reset mid-HALF discards pending slot1.

Structure
REQ-032 SHALL place unit-id encodings, latency table function and pipe-select function in shared package constants.
REQ-033 SHALL implement scoreboard as one sub-module issue_scoreboard (load ports x2, read ports x8, countdown).

Verification
REQ-034 SHALL test: pair fx1 rt=5 / perm ra=6, empty scoreboard -> even_issue=1 slot0, odd_issue=1 slot1, in_ready=1 same cycle.
REQ-035 SHALL test: pair fx2 rt=3 / byte ra=4 (both even) -> cycle0 even slot0, HALF; cycle1 even slot1, in_ready=1.
REQ-036 SHALL test: sp_int rt=10 issued, next pair fx1 ra=10 -> stalls 6 cycles, issues on 7th; stall_cnt=6.
REQ-037 SHALL test: pair ls rt=8 / fx1 ra=8 -> ls issues, HALF, fx1 issues 6 cycles later.
REQ-038 SHALL test: flush asserted in HALF -> no issue that cycle, in_ready=1, state IDLE, sb entries still decrement.
REQ-039 SHALL test: reset low during stall -> all outputs 0 immediately, stall_cnt=0, sb clear after release.

Source files
------------

// File: rtl/issue_control_pkg.sv
// issue_control_pkg: unit encodings, latency table and pipe selection shared by the issue logic
package issue_control_pkg;
  localparam int UNIT_ID_SIZE = 3;
  typedef enum logic [UNIT_ID_SIZE-1:0] {
    U_FX1, U_BYTE, U_FX2, U_PERM, U_LS, U_BRANCH, U_SP_FP, U_SP_INT
  } unit_e;
  typedef enum logic {IDLE, HALF} state_e;
  function automatic logic [2:0] unit_lat(input logic [UNIT_ID_SIZE-1:0] u);
    case (unit_e'(u))
      U_FX1: return 3'd2;
      U_SP_FP, U_LS: return 3'd6;
      U_SP_INT: return 3'd7;
      default: return 3'd3;
    endcase
  endfunction
  function automatic logic unit_odd(input logic [UNIT_ID_SIZE-1:0] u);
    return u == U_PERM || u == U_LS || u == U_BRANCH;
  endfunction
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register result countdown with two load ports and eight read ports
module issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int CNT_W = 3,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ld_en,
  input  logic [AW-1:0]    ld_addr [2],
  input  logic [CNT_W-1:0] ld_lat [2],
  input  logic [AW-1:0]    rd_addr [8],
  output logic [CNT_W-1:0] rd_val [8]
);
  logic [CNT_W-1:0] sb [NUM_REGS];
  // load on issue, otherwise count each pending entry down to zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int r = 0; r < NUM_REGS; r++) sb[r] <= '0;
    else for (int r = 0; r < NUM_REGS; r++)
      sb[r] <= (ld_en[0] && ld_addr[0] == AW'(r)) ? ld_lat[0] :
               (ld_en[1] && ld_addr[1] == AW'(r)) ? ld_lat[1] :
               sb[r] - CNT_W'(sb[r] != '0);
  // reads report cycles still outstanding once this cycle's countdown is applied
  always_comb
    for (int i = 0; i < 8; i++) rd_val[i] = sb[rd_addr[i]] - CNT_W'(sb[rd_addr[i]] != '0);
endmodule

// File: rtl/issue_control.sv
// issue_control: in-order dual-issue of a decoded pair onto even/odd pipes with scoreboard hazards
module issue_control import issue_control_pkg::*; #(
  parameter int NUM_REGS = 128,
  parameter int CNT_W = 3,
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      s0_valid, s1_valid,
  input  logic [UNIT_ID_SIZE-1:0]   s0_unit, s1_unit,
  input  logic                      s0_wr, s1_wr,
  input  logic [REG_ADDR_WIDTH-1:0] s0_rt, s1_rt,
  input  logic [REG_ADDR_WIDTH-1:0] s0_ra, s0_rb, s0_rc,
  input  logic [REG_ADDR_WIDTH-1:0] s1_ra, s1_rb, s1_rc,
  input  logic [2:0]                s0_use, s1_use,
  input  logic                      flush,
  output logic                      even_issue, odd_issue,
  output logic                      even_slot, odd_slot,
  output logic [31:0]               stall_cnt
);
  state_e state;
  logic [REG_ADDR_WIDTH-1:0] rd_addr [8];
  logic [CNT_W-1:0] rv [8];
  logic [CNT_W-1:0] lat0, lat1;
  logic blk0, blk1, dep, iss0, iss1, rdy, go_half;
  assign lat0 = CNT_W'(unit_lat(s0_unit));
  assign lat1 = CNT_W'(unit_lat(s1_unit));
  assign rd_addr = '{s0_ra, s0_rb, s0_rc, s0_rt, s1_ra, s1_rb, s1_rc, s1_rt};
  assign blk0 = (s0_use[0] && rv[0] != '0) || (s0_use[1] && rv[1] != '0) ||
                (s0_use[2] && rv[2] != '0) || (s0_wr && rv[3] > lat0);
  assign blk1 = (s1_use[0] && rv[4] != '0) || (s1_use[1] && rv[5] != '0) ||
                (s1_use[2] && rv[6] != '0) || (s1_wr && rv[7] > lat1);
  assign dep = s0_wr && ((s1_use[0] && s1_ra == s0_rt) || (s1_use[1] && s1_rb == s0_rt) ||
                         (s1_use[2] && s1_rc == s0_rt) || (s1_wr && s1_rt == s0_rt));
  issue_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W), .AW(REG_ADDR_WIDTH)) u_sb (
    .clk(clk), .reset(reset),
    .ld_en({iss1 && s1_wr, iss0 && s0_wr}),
    .ld_addr('{s0_rt, s1_rt}), .ld_lat('{lat0, lat1}),
    .rd_addr(rd_addr), .rd_val(rv)
  );
  // choose which slots issue this cycle; slot1 never overtakes a held slot0
  always_comb begin
    iss0 = 1'b0;
    iss1 = 1'b0;
    rdy = 1'b1;
    go_half = 1'b0;
    if (state == HALF) begin
      iss1 = in_valid && !blk1;
      rdy = iss1;
    end else if (in_valid && s0_valid) begin
      iss0 = !blk0;
      iss1 = !blk0 && s1_valid && unit_odd(s0_unit) != unit_odd(s1_unit) && !dep && !blk1;
      rdy = iss0 && (!s1_valid || iss1);
      go_half = iss0 && s1_valid && !iss1;
    end else if (in_valid && s1_valid) begin
      iss1 = !blk1;
      rdy = iss1;
    end
    if (flush) begin
      iss0 = 1'b0;
      iss1 = 1'b0;
      rdy = 1'b1;
      go_half = 1'b0;
    end
  end
  assign in_ready = reset && rdy;
  assign even_issue = reset && ((iss0 && !unit_odd(s0_unit)) || (iss1 && !unit_odd(s1_unit)));
  assign odd_issue = reset && ((iss0 && unit_odd(s0_unit)) || (iss1 && unit_odd(s1_unit)));
  assign even_slot = reset && iss1 && !unit_odd(s1_unit);
  assign odd_slot = reset && iss1 && unit_odd(s1_unit);
  // pair progress state and saturating stall counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= flush ? IDLE : go_half ? HALF : (state == HALF && iss1) ? IDLE : state;
      if (in_valid && !iss0 && !iss1 && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_issue_control.sv
// tb_issue_control: directed vectors, corner sequences and random pairs against a timestamp model
module tb_issue_control;
  import issue_control_pkg::*;
  logic clk = 0, reset = 0, in_valid = 0, in_ready, flush = 0;
  logic s0_valid = 0, s1_valid = 0, s0_wr = 0, s1_wr = 0;
  logic [2:0] s0_unit = 0, s1_unit = 0, s0_use = 0, s1_use = 0;
  logic [6:0] s0_rt = 0, s1_rt = 0, s0_ra = 0, s0_rb = 0, s0_rc = 0, s1_ra = 0, s1_rb = 0, s1_rc = 0;
  logic even_issue, odd_issue, even_slot, odd_slot;
  logic [31:0] stall_cnt;
  int total = 0, bad = 0;
  int ready_at [128];
  int mc = 0, m_stall = 0, n, sc0;
  bit m_half = 0, exp_rdy;
  logic [4:0] got;
  typedef struct { bit v; logic [2:0] u; bit wr; logic [6:0] rt, ra, rb, rc; logic [2:0] us; } slot_t;
  typedef struct { bit iv; slot_t a, b; logic [4:0] e; } vec_t;
  vec_t tbl [$];

  issue_control dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s0_valid(s0_valid), .s1_valid(s1_valid), .s0_unit(s0_unit), .s1_unit(s1_unit),
    .s0_wr(s0_wr), .s1_wr(s1_wr), .s0_rt(s0_rt), .s1_rt(s1_rt),
    .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc),
    .s0_use(s0_use), .s1_use(s1_use), .flush(flush),
    .even_issue(even_issue), .odd_issue(odd_issue), .even_slot(even_slot), .odd_slot(odd_slot),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic int lat_of(logic [2:0] u);
    case (u)
      U_FX1: return 2;
      U_BYTE, U_FX2, U_PERM, U_BRANCH: return 3;
      U_SP_FP, U_LS: return 6;
      default: return 7;
    endcase
  endfunction
  function automatic bit is_odd(logic [2:0] u);
    return u inside {U_PERM, U_LS, U_BRANCH};
  endfunction
  function automatic bit blocked(logic wr, logic [2:0] u, logic [6:0] rt, ra, rb, rc, logic [2:0] us);
    return (us[0] && ready_at[ra] > mc) || (us[1] && ready_at[rb] > mc) ||
           (us[2] && ready_at[rc] > mc) || (wr && ready_at[rt] - mc > lat_of(u));
  endfunction
  function automatic slot_t mk(logic [2:0] u, bit wr, logic [6:0] rt, logic [6:0] ra, bit ua);
    slot_t s;
    s.v = 1; s.u = u; s.wr = wr; s.rt = rt; s.ra = ra; s.rb = 0; s.rc = 0; s.us = {2'b0, ua};
    return s;
  endfunction
  function automatic slot_t none();
    slot_t s;
    s.v = 0; s.u = 0; s.wr = 0; s.rt = 0; s.ra = 0; s.rb = 0; s.rc = 0; s.us = 0;
    return s;
  endfunction
  function automatic slot_t rnd();
    slot_t s;
    s.v = $urandom_range(0, 4) != 0; s.u = 3'($urandom_range(0, 7)); s.wr = $urandom_range(0, 1) == 1;
    s.rt = 7'($urandom_range(0, 7)); s.ra = 7'($urandom_range(0, 7));
    s.rb = 7'($urandom_range(0, 7)); s.rc = 7'($urandom_range(0, 7)); s.us = 3'($urandom_range(0, 7));
    return s;
  endfunction
  task automatic add(bit iv, slot_t a, slot_t b, logic [4:0] e);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.e = e;
    tbl.push_back(v);
  endtask
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic drive(bit iv, slot_t a, slot_t b, bit fl);
    in_valid = iv; flush = fl;
    s0_valid = a.v; s0_unit = a.u; s0_wr = a.wr; s0_rt = a.rt; s0_ra = a.ra; s0_rb = a.rb; s0_rc = a.rc; s0_use = a.us;
    s1_valid = b.v; s1_unit = b.u; s1_wr = b.wr; s1_rt = b.rt; s1_ra = b.ra; s1_rb = b.rb; s1_rc = b.rc; s1_use = b.us;
  endtask
  task automatic model_reset();
    foreach (ready_at[r]) ready_at[r] = 0;
    m_half = 0; m_stall = 0;
  endtask
  // one clock: check outputs mid-cycle against the model, then advance the model
  task automatic cyc();
    bit b0, b1, dp, du, i0, i1, rdy, nh, o0, o1;
    #3;
    b0 = blocked(s0_wr, s0_unit, s0_rt, s0_ra, s0_rb, s0_rc, s0_use);
    b1 = blocked(s1_wr, s1_unit, s1_rt, s1_ra, s1_rb, s1_rc, s1_use);
    o0 = is_odd(s0_unit); o1 = is_odd(s1_unit);
    dp = s0_wr && ((s1_use[0] && s1_ra == s0_rt) || (s1_use[1] && s1_rb == s0_rt) ||
                   (s1_use[2] && s1_rc == s0_rt) || (s1_wr && s1_rt == s0_rt));
    i0 = 0; i1 = 0; rdy = 1; nh = m_half;
    if (flush) nh = 0;
    else if (m_half) begin i1 = in_valid && !b1; rdy = i1; nh = !i1; end
    else if (in_valid && s0_valid) begin
      i0 = !b0;
      du = i0 && s1_valid && o0 != o1 && !dp && !b1;
      i1 = du; rdy = i0 && (!s1_valid || du); nh = i0 && s1_valid && !du;
    end else if (in_valid && s1_valid) begin i1 = !b1; rdy = i1; end
    got = {in_ready, even_issue, odd_issue, even_slot, odd_slot};
    chk("model_in_ready", in_ready, rdy);
    chk("model_even_issue", even_issue, (i0 && !o0) || (i1 && !o1));
    chk("model_odd_issue", odd_issue, (i0 && o0) || (i1 && o1));
    chk("model_even_slot", even_slot, i1 && !o1);
    chk("model_odd_slot", odd_slot, i1 && o1);
    exp_rdy = rdy;
    @(posedge clk);
    if (i0 && s0_wr) ready_at[s0_rt] = mc + lat_of(s0_unit);
    if (i1 && s1_wr) ready_at[s1_rt] = mc + lat_of(s1_unit);
    if (in_valid && !i0 && !i1) m_stall++;
    m_half = nh; mc++;
    #1;
    chk("model_stall_cnt", stall_cnt, m_stall);
  endtask
  task automatic wait_issue(int lim);
    n = 0;
    for (int k = 0; k < lim; k++) begin
      cyc();
      if (got[3] || got[2]) break;
      n++;
    end
  endtask
  task automatic pulse_reset();
    #1 reset = 0;
    #1;
    chk("rst_outs", {in_ready, even_issue, odd_issue, even_slot, odd_slot}, 5'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    slot_t a, b;
    bit iv, fl, hold;
    model_reset();
    #1;
    chk("reset_outs", {in_ready, even_issue, odd_issue, even_slot, odd_slot}, 5'b0);
    chk("reset_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    // expected = {in_ready, even_issue, odd_issue, even_slot, odd_slot}
    add(1, mk(U_FX1, 1, 5, 0, 0), mk(U_PERM, 0, 0, 6, 1), 5'b11101);
    add(1, mk(U_FX2, 1, 3, 0, 0), mk(U_BYTE, 0, 0, 4, 1), 5'b01000);
    add(1, mk(U_FX2, 1, 3, 0, 0), mk(U_BYTE, 0, 0, 4, 1), 5'b11010);
    add(0, none(), none(), 5'b10000);
    add(1, none(), mk(U_PERM, 0, 0, 5, 1), 5'b10101);
    add(1, mk(U_LS, 1, 8, 0, 0), mk(U_FX1, 0, 0, 8, 1), 5'b00100);
    repeat (5) add(1, mk(U_LS, 1, 8, 0, 0), mk(U_FX1, 0, 0, 8, 1), 5'b00000);
    add(1, mk(U_LS, 1, 8, 0, 0), mk(U_FX1, 0, 0, 8, 1), 5'b11010);
    add(1, mk(U_SP_FP, 1, 12, 0, 0), none(), 5'b11000);
    repeat (5) add(1, mk(U_FX1, 0, 0, 12, 1), mk(U_PERM, 0, 0, 7, 1), 5'b00000);
    add(1, mk(U_FX1, 0, 0, 12, 1), mk(U_PERM, 0, 0, 7, 1), 5'b11101);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].a, tbl[i].b, 0);
      cyc();
      chk($sformatf("vec%0d", i), got, tbl[i].e);
    end
    drive(1, mk(U_SP_INT, 1, 10, 0, 0), none(), 0);
    cyc();
    chk("raw_sp_int_issue", got, 5'b11000);
    sc0 = stall_cnt;
    drive(1, mk(U_FX1, 0, 0, 10, 1), none(), 0);
    wait_issue(15);
    chk("raw_stall_cycles", n, 6);
    chk("raw_stall_cnt_delta", stall_cnt - sc0, 6);
    drive(1, mk(U_SP_INT, 1, 20, 0, 0), mk(U_FX1, 0, 0, 20, 1), 0);
    cyc();
    chk("flush_setup", got, 5'b01000);
    drive(1, mk(U_SP_INT, 1, 20, 0, 0), mk(U_FX1, 0, 0, 20, 1), 1);
    cyc();
    chk("flush_in_half", got, 5'b10000);
    drive(1, mk(U_FX1, 1, 30, 0, 0), mk(U_PERM, 0, 0, 31, 1), 0);
    cyc();
    chk("flush_back_idle", got, 5'b11101);
    drive(1, mk(U_FX1, 0, 0, 20, 1), none(), 0);
    wait_issue(15);
    chk("flush_sb_counts", n, 4);
    drive(1, mk(U_SP_INT, 1, 40, 0, 0), none(), 0);
    cyc();
    drive(1, mk(U_FX1, 0, 0, 40, 1), none(), 0);
    cyc();
    cyc();
    pulse_reset();
    cyc();
    chk("rst_sb_clear", got, 5'b11000);
    drive(1, mk(U_SP_INT, 1, 41, 0, 0), mk(U_FX1, 0, 0, 41, 1), 0);
    cyc();
    chk("rst_half_setup", got, 5'b01000);
    pulse_reset();
    drive(1, mk(U_FX1, 1, 42, 0, 0), mk(U_PERM, 0, 0, 41, 1), 0);
    cyc();
    chk("rst_half_idle", got, 5'b11101);
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!hold) begin
        iv = $urandom_range(0, 9) < 8;
        a = rnd();
        b = rnd();
      end
      fl = $urandom_range(0, 19) == 0;
      drive(iv, a, b, fl);
      cyc();
      hold = iv && !exp_rdy;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
